// File: rtl/cpu_bus_serializer_if.sv
// cpu_bus_serializer_if: CPU request/response signals plus the narrow pad
// lanes of the serializer, bundled for the bridge and its environment.
// master = CPU core and pad environment, slave = the serializer itself.
interface cpu_bus_serializer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LANE_W = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_busy;
   logic [LANE_W-1:0] pad_addr_out;
   logic [LANE_W-1:0] pad_data_out;
   logic [LANE_W-1:0] pad_data_in;
   logic [LANE_W-1:0] pad_data_oe;
   logic [1:0]        pad_phase;
   logic              pad_strobe;
   logic              pad_ready;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, pad_data_in, pad_ready,
      input  cpu_rdata, cpu_ack, cpu_busy, pad_addr_out, pad_data_out,
             pad_data_oe, pad_phase, pad_strobe
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, pad_data_in, pad_ready,
      output cpu_rdata, cpu_ack, cpu_busy, pad_addr_out, pad_data_out,
             pad_data_oe, pad_phase, pad_strobe
   );
endinterface

// File: rtl/cpu_bus_serializer.sv
// cpu_bus_serializer: bridges the core's parallel bus onto LANE_W-wide pads.
// A request goes out as N_A address beats (lane 0 first), then N_D write
// beats, or a one-cycle turnaround plus N_D read beats; a DONE cycle pulses
// cpu_ack and publishes read data. Outputs come straight from flops.
// Optional feature: define SER_WAIT_EN to let pad_ready stall data beats.
module cpu_bus_serializer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LANE_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   cpu_bus_serializer_if.slave bus
);
   localparam int N_A   = ADDR_W / LANE_W;
   localparam int N_D   = DATA_W / LANE_W;
   localparam int N_MAX = (N_A > N_D) ? N_A : N_D;
   localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
   localparam logic [CNT_W-1:0] LAST_A = CNT_W'(N_A - 1);
   localparam logic [CNT_W-1:0] LAST_D = CNT_W'(N_D - 1);

   localparam logic [1:0] PH_IDLE  = 2'b00;
   localparam logic [1:0] PH_ADDR  = 2'b01;
   localparam logic [1:0] PH_WDATA = 2'b10;
   localparam logic [1:0] PH_RDATA = 2'b11;

   if (ADDR_W % LANE_W != 0) begin : g_bad_addr_w
      $error("cpu_bus_serializer: ADDR_W must be a multiple of LANE_W");
   end
   if (DATA_W % LANE_W != 0) begin : g_bad_data_w
      $error("cpu_bus_serializer: DATA_W must be a multiple of LANE_W");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rbuf_q, rbuf_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [LANE_W-1:0] addr_out_q, addr_out_d;
   logic [LANE_W-1:0] data_out_q, data_out_d;
   logic [LANE_W-1:0] oe_q, oe_d;
   logic [1:0]        phase_q, phase_d;
   logic              strobe_q, strobe_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              beat_ok;

   function automatic logic [LANE_W-1:0] addr_lane(input logic [ADDR_W-1:0] v,
                                                    input logic [CNT_W-1:0]  b);
      logic [ADDR_W-1:0] s;
      s = v >> (int'(b) * LANE_W);
      return s[LANE_W-1:0];
   endfunction

   function automatic logic [LANE_W-1:0] data_lane(input logic [DATA_W-1:0] v,
                                                    input logic [CNT_W-1:0]  b);
      logic [DATA_W-1:0] s;
      s = v >> (int'(b) * LANE_W);
      return s[LANE_W-1:0];
   endfunction

`ifdef SER_WAIT_EN
   // Data beats only advance on a ready cycle; strobe is masked while stalled.
   assign beat_ok        = bus.pad_ready;
   assign bus.pad_strobe = strobe_q & (bus.pad_ready | (state_q == S_ADDR));
`else
   logic unused_pad_ready;
   assign unused_pad_ready = bus.pad_ready;
   assign beat_ok          = 1'b1;
   assign bus.pad_strobe   = strobe_q;
`endif

   // Next state, beat counter, latched request, and the next output values.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req) begin
               we_d    = bus.cpu_we;
               addr_d  = bus.cpu_addr;
               wdata_d = bus.cpu_wdata;
               cnt_d   = '0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (cnt_q == LAST_A) begin
               cnt_d   = '0;
               state_d = we_q ? S_WDATA : S_TURN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WDATA: begin
            if (beat_ok) begin
               if (cnt_q == LAST_D) state_d = S_DONE;
               else                 cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_TURN: begin
            cnt_d   = '0;
            state_d = S_RDATA;
         end
         S_RDATA: begin
            if (beat_ok) begin
               // Shift each beat in from the top; after N_D beats beat 0 sits in lane 0.
               rbuf_d = (rbuf_q >> LANE_W) | (DATA_W'(bus.pad_data_in) << (DATA_W - LANE_W));
               if (cnt_q == LAST_D) begin
                  rdata_d = rbuf_d;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the upcoming state so the flops present them in that state.
      addr_out_d = (state_d == S_ADDR)  ? addr_lane(addr_d, cnt_d)  : '0;
      data_out_d = (state_d == S_WDATA) ? data_lane(wdata_d, cnt_d) : '0;
      oe_d       = (state_d == S_WDATA) ? '1 : '0;
      strobe_d   = (state_d == S_ADDR) || (state_d == S_WDATA) || (state_d == S_RDATA);
      ack_d      = (state_d == S_DONE);
      busy_d     = (state_d != S_IDLE);
      case (state_d)
         S_ADDR:  phase_d = PH_ADDR;
         S_WDATA: phase_d = PH_WDATA;
         S_RDATA: phase_d = PH_RDATA;
         default: phase_d = PH_IDLE;
      endcase
   end

   // State, request latches and output flops; reset aborts any transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rbuf_q     <= '0;
         rdata_q    <= '0;
         addr_out_q <= '0;
         data_out_q <= '0;
         oe_q       <= '0;
         phase_q    <= PH_IDLE;
         strobe_q   <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         rdata_q    <= rdata_d;
         addr_out_q <= addr_out_d;
         data_out_q <= data_out_d;
         oe_q       <= oe_d;
         phase_q    <= phase_d;
         strobe_q   <= strobe_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.cpu_rdata    = rdata_q;
   assign bus.cpu_ack      = ack_q;
   assign bus.cpu_busy     = busy_q;
   assign bus.pad_addr_out = addr_out_q;
   assign bus.pad_data_out = data_out_q;
   assign bus.pad_data_oe  = oe_q;
   assign bus.pad_phase    = phase_q;
endmodule

// File: tb/tb_cpu_bus_serializer.sv
// tb_cpu_bus_serializer: directed transactions with literal expectations plus
// random traffic checked every cycle against a transaction-level model that
// expands each accepted request into its expected beat sequence.
module tb_cpu_bus_serializer;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LANE_W = 8;
   localparam int N_A    = ADDR_W / LANE_W;
   localparam int N_D    = DATA_W / LANE_W;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   model_on = 1'b1;

   always #5 clk = ~clk;

   cpu_bus_serializer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) bus ();

   cpu_bus_serializer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One expected cycle of a transaction.
   typedef struct {
      logic [1:0]        phase;  // 01 addr, 10 wdata, 11 rdata, 00 turn/done
      logic [LANE_W-1:0] lane;   // expected pad lane for addr/wdata beats
      int                idx;    // read beat index
      logic              ack;
      logic              rd;
   } beat_t;

   beat_t             exp_q[$];
   logic [LANE_W-1:0] rd_lane [N_D];
   logic [DATA_W-1:0] model_rdata;

   task automatic push_txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      for (int b = 0; b < N_A; b++) begin
         exp_q.push_back('{phase: 2'b01, lane: a[LANE_W-1:0], idx: b, ack: 1'b0, rd: 1'b0});
         a = a >> LANE_W;
      end
      if (we) begin
         for (int b = 0; b < N_D; b++) begin
            exp_q.push_back('{phase: 2'b10, lane: d[LANE_W-1:0], idx: b, ack: 1'b0, rd: 1'b0});
            d = d >> LANE_W;
         end
      end else begin
         exp_q.push_back('{phase: 2'b00, lane: '0, idx: 0, ack: 1'b0, rd: 1'b0});
         for (int b = 0; b < N_D; b++)
            exp_q.push_back('{phase: 2'b11, lane: '0, idx: b, ack: 1'b0, rd: 1'b0});
      end
      exp_q.push_back('{phase: 2'b00, lane: '0, idx: 0, ack: 1'b1, rd: !we});
   endtask

   // Compare process: outputs of the current cycle against the model.
   always @(negedge clk) begin : cmp
      beat_t             e;
      logic [DATA_W-1:0] acc;
      if (!rst_n) begin
         exp_q.delete();
         model_rdata = '0;
         check("rst_busy",   64'(bus.cpu_busy),     64'd0);
         check("rst_ack",    64'(bus.cpu_ack),      64'd0);
         check("rst_phase",  64'(bus.pad_phase),    64'd0);
         check("rst_oe",     64'(bus.pad_data_oe),  64'd0);
         check("rst_strobe", 64'(bus.pad_strobe),   64'd0);
         check("rst_addr",   64'(bus.pad_addr_out), 64'd0);
         check("rst_data",   64'(bus.pad_data_out), 64'd0);
         check("rst_rdata",  64'(bus.cpu_rdata),    64'd0);
      end else if (model_on) begin
         if (exp_q.size() == 0) begin
            check("idle_busy",   64'(bus.cpu_busy),    64'd0);
            check("idle_ack",    64'(bus.cpu_ack),     64'd0);
            check("idle_phase",  64'(bus.pad_phase),   64'd0);
            check("idle_oe",     64'(bus.pad_data_oe), 64'd0);
            check("idle_strobe", 64'(bus.pad_strobe),  64'd0);
            check("idle_rdata",  64'(bus.cpu_rdata),   64'(model_rdata));
            if (bus.cpu_req) push_txn(bus.cpu_we, bus.cpu_addr, bus.cpu_wdata);
         end else begin
            e = exp_q.pop_front();
            check("m_phase",  64'(bus.pad_phase),   64'(e.phase));
            check("m_strobe", 64'(bus.pad_strobe),  64'(e.phase != 2'b00));
            check("m_oe",     64'(bus.pad_data_oe), (e.phase == 2'b10) ? 64'hFF : 64'd0);
            check("m_busy",   64'(bus.cpu_busy),    64'd1);
            check("m_ack",    64'(bus.cpu_ack),     64'(e.ack));
            if (e.phase == 2'b01) check("m_addr_lane", 64'(bus.pad_addr_out), 64'(e.lane));
            if (e.phase == 2'b10) check("m_data_lane", 64'(bus.pad_data_out), 64'(e.lane));
            if (e.phase == 2'b11) rd_lane[e.idx] = bus.pad_data_in;
            if (e.ack && e.rd) begin
               acc = '0;
               for (int i = 0; i < N_D; i++) acc |= DATA_W'(rd_lane[i]) << (i * LANE_W);
               model_rdata = acc;
            end
            check("m_rdata", 64'(bus.cpu_rdata), 64'(model_rdata));
         end
      end
   end

   // Issue one request from an idle cycle and record what the pads show until ack.
   task automatic txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [DATA_W-1:0] rd, input int stall,
                      output int ack_c, output logic [ADDR_W-1:0] a_s, output logic [DATA_W-1:0] d_s,
                      output logic [DATA_W-1:0] r_s, output logic [LANE_W-1:0] oe_s, output int turn_c);
      int na, nd, nr, st;
      na = 0; nd = 0; nr = 0; st = 0;
      ack_c = -1; a_s = '0; d_s = '0; r_s = '0; oe_s = '0; turn_c = 0;
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         oe_s |= bus.pad_data_oe;
         if (bus.pad_strobe && bus.pad_phase == 2'b01) begin
            a_s |= ADDR_W'(bus.pad_addr_out) << (na * LANE_W);
            na++;
         end
         if (bus.pad_strobe && bus.pad_phase == 2'b10) begin
            d_s |= DATA_W'(bus.pad_data_out) << (nd * LANE_W);
            nd++;
         end
         if (bus.cpu_busy && bus.pad_phase == 2'b00 && !bus.cpu_ack) turn_c++;
         if (bus.pad_phase == 2'b11) begin
            if (nr == 1 && st < stall) begin
               bus.pad_ready   = 1'b0;
               bus.pad_data_in = LANE_W'($urandom);
               st++;
            end else begin
               bus.pad_ready   = 1'b1;
               bus.pad_data_in = LANE_W'(rd >> (nr * LANE_W));
               nr++;
            end
         end
         if (bus.cpu_ack) begin
            ack_c = c;
            r_s   = bus.cpu_rdata;
            break;
         end
         @(posedge clk); #1;
      end
      bus.pad_ready = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.cpu_busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(bus.cpu_busy), 64'd0);
   endtask

   initial begin
      int                ack_c, turn_c, acks, first, second, nw;
      bit                hit;
      logic [ADDR_W-1:0] a_s;
      logic [DATA_W-1:0] d_s, r_s;
      logic [LANE_W-1:0] oe_s;

      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.pad_data_in = '0; bus.pad_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",  64'(bus.cpu_busy),  64'd0);
      check("reset_rdata", 64'(bus.cpu_rdata), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Write: lanes go out little-endian, ack on cycle 9.
      txn(1'b1, 32'h12345678, 32'hCAFEBABE, '0, 0, ack_c, a_s, d_s, r_s, oe_s, turn_c);
      check("t1_ack_cycle", 64'(ack_c), 64'd9);
      check("t1_addr",      64'(a_s),   64'h12345678);
      check("t1_wdata",     64'(d_s),   64'hCAFEBABE);
      check("t1_oe",        64'(oe_s),  64'hFF);
      check("t1_turn",      64'(turn_c), 64'd0);
      @(posedge clk); #1;
      check("t1_busy_after", 64'(bus.cpu_busy), 64'd0);
      check("t1_ack_after",  64'(bus.cpu_ack),  64'd0);

      // Read: one turnaround cycle, ack with assembled data on cycle 10.
      txn(1'b0, 32'h4, '0, 32'hDEADBEEF, 0, ack_c, a_s, d_s, r_s, oe_s, turn_c);
      check("t2_ack_cycle", 64'(ack_c),  64'd10);
      check("t2_rdata",     64'(r_s),    64'hDEADBEEF);
      check("t2_oe",        64'(oe_s),   64'd0);
      check("t2_turn",      64'(turn_c), 64'd1);
      check("t2_addr",      64'(a_s),    64'h4);
      @(posedge clk); #1;

      // Reset during WDATA beat 2 aborts the write.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h12345678; bus.cpu_wdata = 32'hCAFEBABE;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      nw = 0; hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (bus.pad_phase == 2'b10) begin
            if (nw == 2) hit = 1'b1;
            else         nw++;
         end
         if (!hit) begin @(posedge clk); #1; end
      end
      check("t4_reached_beat2", 64'(hit), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t4_oe",    64'(bus.pad_data_oe), 64'd0);
      check("t4_phase", 64'(bus.pad_phase),   64'd0);
      check("t4_ack",   64'(bus.cpu_ack),     64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(1'b1, 32'h12345678, 32'hCAFEBABE, '0, 0, ack_c, a_s, d_s, r_s, oe_s, turn_c);
      check("t4_redo_ack_cycle", 64'(ack_c), 64'd9);
      check("t4_redo_addr",      64'(a_s),   64'h12345678);
      check("t4_redo_wdata",     64'(d_s),   64'hCAFEBABE);
      @(posedge clk); #1;

      // Request held high: back-to-back writes, ack-to-ack spacing 10.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'hA5A5_0F0F; bus.cpu_wdata = 32'h0123_4567;
      first = -1; second = -1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus.cpu_ack) begin
            if (first < 0)       first = c;
            else if (second < 0) second = c;
         end
      end
      bus.cpu_req = 1'b0;
      check("t5_ack_gap", 64'(second - first), 64'd10);
      wait_idle("t5_idle_bound");
      @(posedge clk); #1;

      // A pulse while busy is dropped: only one ack follows.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.cpu_req = 1'b1;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      acks = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.cpu_ack) acks++;
         @(posedge clk); #1;
      end
      check("t5_dropped_pulse", 64'(acks), 64'd1);

      // Random traffic with one mid-run reset; the model checks every cycle.
      acks = 0;
      for (int c = 0; c < 400; c++) begin
         if (bus.cpu_ack) acks++;
         bus.cpu_req     = ($urandom_range(0, 2) == 0);
         bus.cpu_we      = 1'($urandom_range(0, 1));
         bus.cpu_addr    = ADDR_W'($urandom);
         bus.cpu_wdata   = DATA_W'($urandom);
         bus.pad_data_in = LANE_W'($urandom);
         if (c == 200) rst_n = 1'b0;
         if (c == 202) rst_n = 1'b1;
         @(posedge clk); #1;
      end
      bus.cpu_req = 1'b0;
      check("rand_acks_seen", 64'(acks > 10), 64'd1);
      wait_idle("rand_idle_bound");
      @(posedge clk); #1;

`ifdef SER_WAIT_EN
      // Stalled read: beat 1 waits 3 cycles; lane 1 keeps only the ready-cycle value.
      model_on = 1'b0;
      txn(1'b0, 32'h4, '0, 32'hDEADBEEF, 3, ack_c, a_s, d_s, r_s, oe_s, turn_c);
      check("t3_ack_cycle", 64'(ack_c), 64'd13);
      check("t3_rdata",     64'(r_s),   64'hDEADBEEF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
